// File: rtl/alsu_pipe_param_if.sv
`default_nettype none
// ============================================================================
// Module   : alsu_pipe_param_if
// Brief    : Operand/control bundle and registered result of the pipelined ALSU.
// Revision : 1.0 - initial release
// ============================================================================
interface alsu_pipe_param_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16
);
    logic                 in_valid;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 cin;
    logic                 serial_in;
    logic                 red_op_A;
    logic                 red_op_B;
    logic [2:0]           opcode;
    logic                 bypass_A;
    logic                 bypass_B;
    logic                 direction;
    logic [2*WIDTH-1:0]   out;
    logic                 out_valid;
    logic [LED_W-1:0]     leds;
    logic                 invalid;

    modport master (
        output in_valid, A, B, cin, serial_in, red_op_A, red_op_B,
               opcode, bypass_A, bypass_B, direction,
        input  out, out_valid, leds, invalid
    );

    modport slave (
        input  in_valid, A, B, cin, serial_in, red_op_A, red_op_B,
               opcode, bypass_A, bypass_B, direction,
        output out, out_valid, leds, invalid
    );
endinterface
`default_nettype wire

// File: rtl/alsu_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : alsu_pipe_param
// Brief    : Two-stage parametrised arithmetic/logic/shift unit with valid pipe.
// Revision : 1.0 - initial release
// ============================================================================
module alsu_pipe_param #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter bit FULL_ADDER     = 1'b1,
    parameter int LED_W          = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alsu_pipe_param_if.slave    bus
);
    localparam int       OUT_W      = 2 * WIDTH;
    localparam bit       c_PRIO_A   = (INPUT_PRIORITY == "A");
    localparam logic [2:0] c_OP_OR    = 3'd0;
    localparam logic [2:0] c_OP_XOR   = 3'd1;
    localparam logic [2:0] c_OP_ADD   = 3'd2;
    localparam logic [2:0] c_OP_MULT  = 3'd3;
    localparam logic [2:0] c_OP_SHIFT = 3'd4;
    localparam logic [2:0] c_OP_ROT   = 3'd5;
    localparam logic [2:0] c_OP_SUB   = 3'd6;

    logic             r_valid1;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_cin, r_serial, r_red_a, r_red_b;
    logic             r_byp_a, r_byp_b, r_dir;
    logic [2:0]       r_opcode;
    logic [OUT_W-1:0] r_out;
    logic [LED_W-1:0] r_leds;
    logic             r_invalid;
    logic             r_out_valid;

    logic [OUT_W-1:0] w_a_ext, w_b_ext, w_cin_ext, w_next_out;
    logic             w_invalid, w_sel_red_a, w_sel_byp_a, w_red_bit;

    assign w_a_ext   = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_b_ext   = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_cin_ext = {{(OUT_W-1){1'b0}}, (FULL_ADDER & r_cin)};

    always_comb begin
        w_invalid   = (r_opcode == 3'd7) ||
                      ((r_red_a || r_red_b) && (r_opcode >= c_OP_ADD));
        // One flag alone wins outright; priority only breaks a tie.
        w_sel_red_a = r_red_a && (!r_red_b || c_PRIO_A);
        w_sel_byp_a = r_byp_a && (!r_byp_b || c_PRIO_A);
        if (r_opcode == c_OP_OR)
            w_red_bit = w_sel_red_a ? |r_a : |r_b;
        else
            w_red_bit = w_sel_red_a ? ^r_a : ^r_b;

        w_next_out = '0;
        if (w_invalid) begin
            w_next_out = '0;
        end else if (r_byp_a || r_byp_b) begin
            w_next_out = w_sel_byp_a ? w_a_ext : w_b_ext;
        end else if (r_red_a || r_red_b) begin
            w_next_out = {{(OUT_W-1){1'b0}}, w_red_bit};
        end else begin
            case (r_opcode)
                c_OP_OR:    w_next_out = w_a_ext | w_b_ext;
                c_OP_XOR:   w_next_out = w_a_ext ^ w_b_ext;
                c_OP_ADD:   w_next_out = w_a_ext + w_b_ext + w_cin_ext;
                // Low OUT_W bits of the sign-extended product are the exact signed product.
                c_OP_MULT:  w_next_out = w_a_ext * w_b_ext;
                c_OP_SHIFT: w_next_out = r_dir ? {r_out[OUT_W-2:0], r_serial}
                                               : {r_serial, r_out[OUT_W-1:1]};
                c_OP_ROT:   w_next_out = r_dir ? {r_out[OUT_W-2:0], r_out[OUT_W-1]}
                                               : {r_out[0], r_out[OUT_W-1:1]};
                c_OP_SUB:   w_next_out = w_a_ext - w_b_ext - w_cin_ext;
                default:    w_next_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid1    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_serial    <= 1'b0;
            r_red_a     <= 1'b0;
            r_red_b     <= 1'b0;
            r_byp_a     <= 1'b0;
            r_byp_b     <= 1'b0;
            r_dir       <= 1'b0;
            r_opcode    <= '0;
            r_out       <= '0;
            r_leds      <= '0;
            r_invalid   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_valid1    <= bus.in_valid;
            r_a         <= bus.A;
            r_b         <= bus.B;
            r_cin       <= bus.cin;
            r_serial    <= bus.serial_in;
            r_red_a     <= bus.red_op_A;
            r_red_b     <= bus.red_op_B;
            r_byp_a     <= bus.bypass_A;
            r_byp_b     <= bus.bypass_B;
            r_dir       <= bus.direction;
            r_opcode    <= bus.opcode;
            r_out_valid <= r_valid1;
            if (r_valid1) begin
                r_out     <= w_next_out;
                r_leds    <= w_invalid ? ~r_leds : '0;
                r_invalid <= w_invalid;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.leds      = r_leds;
    assign bus.invalid   = r_invalid;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_alsu_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_alsu_pipe_param
// Brief    : Directed scoreboard bench for alsu_pipe_param (WIDTH=3, LED_W=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alsu_pipe_param;
    typedef struct packed {
        logic [5:0]  out;
        logic [15:0] leds;
        logic        inv;
    } exp_t;

    // side-signal bits: {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
    localparam logic [6:0] S_CIN = 7'b1000000;
    localparam logic [6:0] S_SER = 7'b0100000;
    localparam logic [6:0] S_RA  = 7'b0010000;
    localparam logic [6:0] S_RB  = 7'b0001000;
    localparam logic [6:0] S_BA  = 7'b0000100;
    localparam logic [6:0] S_BB  = 7'b0000010;
    localparam logic [6:0] S_DIR = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    alsu_pipe_param_if #(.WIDTH(3), .LED_W(16)) bus ();

    alsu_pipe_param #(
        .WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER(1'b1), .LED_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.opcode    = '0;
        {bus.cin, bus.serial_in, bus.red_op_A, bus.red_op_B,
         bus.bypass_A, bus.bypass_B, bus.direction} = '0;
    endtask

    task automatic issue(input logic [2:0] opc, input logic [2:0] a, input logic [2:0] b,
                         input logic [6:0] side, input logic [5:0] e_out,
                         input logic [15:0] e_leds, input logic e_inv, input bit push = 1'b1);
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.A        = a;
        bus.B        = b;
        {bus.cin, bus.serial_in, bus.red_op_A, bus.red_op_B,
         bus.bypass_A, bus.bypass_B, bus.direction} = side;
        if (push) begin
            e.out  = e_out;
            e.leds = e_leds;
            e.inv  = e_inv;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out",     {26'd0, bus.out},  {26'd0, e.out});
                    check("leds",    {16'd0, bus.leds}, {16'd0, e.leds});
                    check("invalid", {31'd0, bus.invalid}, {31'd0, e.inv});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom);
            bus.A        = 3'($urandom);
            bus.B        = 3'($urandom);
            bus.opcode   = 3'($urandom);
            {bus.cin, bus.serial_in, bus.red_op_A, bus.red_op_B,
             bus.bypass_A, bus.bypass_B, bus.direction} = 7'($urandom);
        end
        @(negedge clk);
        check("rst_out",       {26'd0, bus.out},  32'd0);
        check("rst_leds",      {16'd0, bus.leds}, 32'd0);
        check("rst_invalid",   {31'd0, bus.invalid},   32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        drive_idle();
        rst = 1'b1;

        issue(3'd2, 3'd3, 3'd2, S_CIN, 6'b000110, 16'h0000, 1'b0);   // 3+2+1
        issue(3'd6, 3'd1, 3'd3, 7'd0,  6'b111110, 16'h0000, 1'b0);   // 1-3
        issue(3'd2, 3'd3, 3'd3, S_CIN, 6'b000111, 16'h0000, 1'b0);   // 3+3+1
        issue(3'd6, 3'd4, 3'd3, S_CIN, 6'b111000, 16'h0000, 1'b0);   // -4-3-1
        issue(3'd3, 3'd4, 3'd4, 7'd0,  6'b010000, 16'h0000, 1'b0);   // -4*-4
        issue(3'd3, 3'd3, 3'd4, 7'd0,  6'b110100, 16'h0000, 1'b0);   // 3*-4
        issue(3'd0, 3'b101, 3'b010, 7'd0, 6'b111111, 16'h0000, 1'b0);
        issue(3'd1, 3'b101, 3'b011, 7'd0, 6'b111110, 16'h0000, 1'b0);
        issue(3'd7, 3'd1, 3'd1, 7'd0,  6'b000000, 16'hFFFF, 1'b1);
        issue(3'd7, 3'd1, 3'd1, 7'd0,  6'b000000, 16'h0000, 1'b1);
        issue(3'd7, 3'd1, 3'd1, 7'd0,  6'b000000, 16'hFFFF, 1'b1);
        issue(3'd0, 3'b010, 3'd0, S_RA, 6'b000001, 16'h0000, 1'b0);
        issue(3'd1, 3'd0, 3'b111, S_RB, 6'b000001, 16'h0000, 1'b0);
        issue(3'd0, 3'd0, 3'b111, S_RA | S_RB, 6'b000000, 16'h0000, 1'b0);
        issue(3'd2, 3'd1, 3'd1, S_RA,  6'b000000, 16'hFFFF, 1'b1);   // reduction on ADD
        issue(3'd2, 3'd3, 3'd2, S_CIN, 6'b000110, 16'h0000, 1'b0);
        issue(3'd4, 3'd0, 3'd0, S_SER | S_DIR, 6'b001101, 16'h0000, 1'b0);
        issue(3'd5, 3'd0, 3'd0, 7'd0,  6'b100110, 16'h0000, 1'b0);
        issue(3'd4, 3'd0, 3'd0, 7'd0,  6'b010011, 16'h0000, 1'b0);
        issue(3'd5, 3'd0, 3'd0, S_DIR, 6'b100110, 16'h0000, 1'b0);
        issue(3'd0, 3'b111, 3'd2, S_BA | S_BB, 6'b111111, 16'h0000, 1'b0);
        issue(3'd7, 3'b111, 3'd2, S_BA | S_BB, 6'b000000, 16'hFFFF, 1'b1);
        issue(3'd0, 3'b111, 3'd2, S_BB, 6'b000010, 16'h0000, 1'b0);

        idle(4);
        @(negedge clk);
        check("gap_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("gap_out_hold",  {26'd0, bus.out},       32'd2);

        // op enters stage 1, then reset lands before it can reach stage 2
        issue(3'd2, 3'd1, 3'd1, 7'd0, 6'd0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_out",       {26'd0, bus.out},       32'd0);
        idle(2);
        @(negedge clk);
        check("midrst_no_late_valid", {31'd0, bus.out_valid}, 32'd0);

        issue(3'd2, 3'd1, 3'd1, 7'd0, 6'b000010, 16'h0000, 1'b0);
        idle(1);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
